// File: rtl/multiplier_seq_param_if.sv
// Operand/product handshake bundle for multiplier_seq_param.
// master drives operands and accepts products; slave is the multiplier.
interface multiplier_seq_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 tc;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, tc, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, tc, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/multiplier_seq_param.sv
// Iterative shift-add multiplier, unsigned or two's-complement per transaction.
// Operands are reduced to magnitudes on capture, multiplied over up to WIDTH RUN
// cycles, and the sign is applied in a single SIGN cycle.
// Optional macro MULT_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (same results, shorter latency).
module multiplier_seq_param #(
  parameter int unsigned WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  multiplier_seq_param_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StSign, StDone} state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [2*WIDTH-1:0]   acc_q;
  // Multiplicand pre-shifted by count, so no barrel shifter is needed.
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mb_q;
  logic [CW-1:0]        count_q;
  logic                 neg_q;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 run_last;

  // Operand magnitudes; -(-2^(W-1)) wraps to 2^(W-1), which is correct unsigned.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.tc && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (bus.tc && bus.b[WIDTH-1]) b_mag = -bus.b;
  end

  // Last RUN cycle: all WIDTH bits consumed, or (optionally) nothing left to add.
  always_comb begin
    run_last = (count_q == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
    if (mb_q[WIDTH-1:1] == '0) run_last = 1'b1;
`else
`endif
  end

  // Control FSM and datapath with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mb_q        <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            mcand_q    <= {{WIDTH{1'b0}}, a_mag};
            mb_q       <= b_mag;
            neg_q      <= bus.tc & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (mb_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          mb_q    <= mb_q >> 1;
          count_q <= count_q + CW'(1);
          if (run_last) state_q <= StSign;
        end
        StSign: begin
          product_q   <= neg_q ? -acc_q : acc_q;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          // New operands are only considered once back in IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_multiplier_seq_param.sv
// Self-checking bench for multiplier_seq_param: directed vectors, backpressure,
// mid-run reset, back-to-back random traffic and latency checks.
module tb_multiplier_seq_param;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multiplier_seq_param_if #(.WIDTH(W)) bus ();

  multiplier_seq_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic tc);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    if (tc) return sa * sb;
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Edge index (after the accept edge) at which out_valid is first seen high.
  function automatic int model_lat(input logic [W-1:0] b, input logic tc);
    logic [W-1:0] mb;
    int n;
    mb = (tc && b[W-1]) ? -b : b;
    n  = W;
`ifdef MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < int'(W); i++) if (mb[i]) n = i + 1;
`else
`endif
    return n + 1;
  endfunction

  // Drives one transaction and returns the observed latency and product (-1 on timeout).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic tc,
                       output int lat, output logic [2*W-1:0] prod);
    int guard;
    guard = 0;
    exp_q.push_back(model_prod(a, b, tc));
    lat_q.push_back(model_lat(b, tc));
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.a = a; bus.b = b; bus.tc = tc; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble operands after capture; the result must not depend on them.
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.tc = ~tc;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    prod = bus.product;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    vectors++;
    if (bus.product !== '0) begin
      errors++; $display("FAIL reset_product got=%h want=0", bus.product);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Applies a list of directed vectors, checking product, literal value and latency.
  task automatic test_directed();
    logic [W-1:0]   av[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [W-1:0]   bv[5] = '{32'hFFFFFFFF, 32'h3489BE8F, 32'h3489BE8F, 32'h80000000, 32'h00000001};
    logic           tv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2*W-1:0] lit[5] = '{64'hFFFFFFFE00000001, 64'hFFFFFFFFCB764171, 64'h3489BE8ECB764171,
                               64'h4000000000000000, 64'hFFFFFFFF80000000};
    int             lat;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    int             elat;
    for (int i = 0; i < 5; i++) begin
      issue(av[i], bv[i], tv[i], lat, prod);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      vectors++;
      if (prod !== exp) begin
        errors++; $display("FAIL directed_%0d_product got=%h want=%h", i, prod, exp);
      end
      vectors++;
      if (prod !== lit[i]) begin
        errors++; $display("FAIL directed_%0d_literal got=%h want=%h", i, prod, lit[i]);
      end
      vectors++;
      if (lat != elat) begin
        errors++; $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, elat);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int             lat;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    int             elat;
    issue(32'h12345678, 32'h9ABCDEF0, 1'b1, lat, prod);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    vectors++;
    if (prod !== exp) begin
      errors++; $display("FAIL bp_product got=%h want=%h", prod, exp);
    end
    vectors++;
    if (lat != elat) begin
      errors++; $display("FAIL bp_latency got=%0d want=%0d", lat, elat);
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = c[0];
      bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.product !== exp || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got ov=%b rdy=%b p=%h want ov=1 rdy=0 p=%h",
                 c, bus.out_valid, bus.in_ready, bus.product, exp);
      end
    end
    // Retire with in_valid high: the new operands must not be taken on that edge.
    bus.in_valid = 1'b1;
    retire();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b ov=%b want rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
    vectors++;
    if (bus.product !== exp) begin
      errors++; $display("FAIL bp_product_kept got=%h want=%h", bus.product, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    int             lat;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    int             elat;
    bus.a = 32'hDEADBEEF; bus.b = 32'hFFFFFFFF; bus.tc = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.product !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state got ov=%b p=%h rdy=%b want ov=0 p=0 rdy=1",
               bus.out_valid, bus.product, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    issue(32'd3, 32'd5, 1'b0, lat, prod);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    vectors++;
    if (prod !== 64'd15 || prod !== exp) begin
      errors++; $display("FAIL midrst_next got=%h want=%h", prod, exp);
    end
    vectors++;
    if (lat != elat) begin
      errors++; $display("FAIL midrst_latency got=%0d want=%0d", lat, elat);
    end
    retire();
  endtask

  task automatic test_early_term();
    logic [W-1:0]   bv[3] = '{32'h00000000, 32'h00000001, 32'h00000100};
    int             lat;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    int             elat;
    for (int i = 0; i < 3; i++) begin
      issue(32'h0000A5C3, bv[i], 1'b0, lat, prod);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      vectors++;
      if (prod !== exp) begin
        errors++; $display("FAIL early_%0d_product got=%h want=%h", i, prod, exp);
      end
      vectors++;
      if (lat != elat) begin
        errors++; $display("FAIL early_%0d_latency got=%0d want=%0d", i, lat, elat);
      end
      retire();
    end
  endtask

  // out_ready held high: each result is retired the cycle after it appears.
  task automatic test_back_to_back();
    int             lat;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    int             elat;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'h80000000 : $urandom >> (i * 4);
      issue(a, b, i[0], lat, prod);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      vectors++;
      if (prod !== exp) begin
        errors++; $display("FAIL b2b_%0d_product got=%h want=%h", i, prod, exp);
      end
      vectors++;
      if (lat != elat) begin
        errors++; $display("FAIL b2b_%0d_latency got=%0d want=%0d", i, lat, elat);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.tc        = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_early_term();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_seq_param.md
# multiplier_seq_param

Parametrised, iterative shift-add multiplier with valid/ready handshakes on input and output. It computes a 2*WIDTH-bit product of two WIDTH-bit operands in either unsigned or two's-complement mode, selected per transaction. It is the sequential, area-lean successor to the fixed 32-bit combinational multipliers, for datapaths that can tolerate multi-cycle latency. Optional early termination shortens latency for small multipliers.

## Interface
- WIDTH, 32, operand width in bits; legal range is WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- tc  input  1  0 = unsigned, 1 = two's-complement signed.
- out_valid  output  1  product is valid; held until accepted.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result; holds its value while out_valid is high.

## Operation
- States: IDLE, RUN, SIGN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid the block captures operands and goes to RUN.
  - Capture: magnitudes ma = |a| and mb = |b| when tc = 1, raw a and b when tc = 0. neg = tc & (a[W-1] ^ b[W-1]).
  - Clear the accumulator and the counter.
- RUN, once per cycle:
  - If mb[0] = 1, add ma << count into the 2W-bit accumulator.
  - Shift mb right by 1 and increment count.
  - Exit to SIGN when count reaches WIDTH-1 on this cycle, i.e. after WIDTH RUN cycles.
- SIGN:
  - product <= neg ? -acc : acc (2W-bit two's-complement negate).
  - Go to DONE with out_valid = 1.
- DONE:
  - out_valid = 1 and product is stable.
  - On out_ready, go to IDLE and clear out_valid. product keeps its last value.
- Width rules:
  - |-2^(W-1)| = 2^(W-1) fits in W unsigned bits.
  - The largest magnitude product, 2^(2W-2) in signed mode or (2^W-1)^2 in unsigned mode, fits in 2W bits without overflow.
- Operand changes after the capture edge are ignored. in_valid outside IDLE is ignored and not queued.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, product = 0, accumulator = 0, count = 0.
- Reset asserted mid-operation aborts the transaction at once with no output. The block is ready in IDLE after reset deasserts.
- Edge 0 is the accepting edge (in_valid & in_ready).
  - With n RUN cycles, out_valid becomes high after edge n+1.
  - Default latency: n = WIDTH, so out_valid is high after edge 33 for WIDTH = 32.
- in_ready falls after edge 0. It rises again the edge after out_valid & out_ready.
- Throughput without backpressure is one result per WIDTH+3 cycles.
- Backpressure: with out_ready held low, DONE persists indefinitely with product constant.
- out_valid & out_ready and in_valid in the same cycle: the output is retired. The new operands are not accepted until the following IDLE cycle.

## Configuration
- MULT_EARLY_TERM_EN defined:
  - RUN also exits to SIGN when the post-shift mb equals 0. n = max(1, index of the highest set bit of mb + 1).
  - mb = 0 or mb = 1 both give n = 1, so out_valid is high after edge 2.
- MULT_EARLY_TERM_EN undefined:
  - n = WIDTH for every operand.
  - No zero-detect logic on mb.
- Results are identical with and without the macro; only latency differs.

## Test plan
- Unsigned, WIDTH = 32, a = 0xFFFFFFFF, b = 0xFFFFFFFF, tc = 0 -> product = 0xFFFFFFFE00000001, out_valid after edge 33 without the macro.
- Signed, a = 0xFFFFFFFF, b = 0x3489BE8F, tc = 1 -> product = 0xFFFFFFFFCB764171. Same operands with tc = 0 -> product = 0x3489BE8ECB764171.
- Signed extreme, a = b = 0x80000000, tc = 1 -> product = 0x4000000000000000. a = 0x80000000, b = 0x00000001, tc = 1 -> product = 0xFFFFFFFF80000000.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> product and out_valid stable, in_ready = 0 throughout, in_valid pulses ignored. Then assert out_ready for 1 cycle -> in_ready = 1 the next cycle.
- Reset mid-RUN: assert rst at cycle 10 of a transaction -> out_valid = 0, product = 0, in_ready = 1 immediately. The next transaction a = 3, b = 5, tc = 0 -> product = 15.
- With MULT_EARLY_TERM_EN, b = 0 and b = 1 -> out_valid after edge 2. b = 0x00000100 -> out_valid after edge 10, product = a << 8.
